// File: rtl/regbank_wb_arbiter_if.sv
// rtl/regbank_wb_arbiter_if.sv - write-back request/response bundle for regbank_wb_arbiter
// Optional busy scoreboard port present when REGBANK_SCOREBOARD_EN is defined.
interface regbank_wb_arbiter_if #(
  parameter int DW   = 32,
  parameter int NREG = 16
);
  localparam int AW = $clog2(NREG);

  logic            flush;
  logic            alu_valid;
  logic [AW-1:0]   alu_dest;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            ldr_valid;
  logic [AW-1:0]   ldr_dest;
  logic [DW-1:0]   ldr_data;
  logic            ldr_ready;
  logic [NREG-1:0] en;
  logic [DW-1:0]   wdata;
`ifdef REGBANK_SCOREBOARD_EN
  logic [NREG-1:0] busy;
`endif

  modport master (
    output flush, alu_valid, alu_dest, alu_data, ldr_valid, ldr_dest, ldr_data,
    input  alu_ready, ldr_ready, en, wdata
`ifdef REGBANK_SCOREBOARD_EN
    , input busy
`endif
  );

  modport slave (
    input  flush, alu_valid, alu_dest, alu_data, ldr_valid, ldr_dest, ldr_data,
    output alu_ready, ldr_ready, en, wdata
`ifdef REGBANK_SCOREBOARD_EN
    , output busy
`endif
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// rtl/regbank_wb_arbiter.sv - two-source register bank write-back scheduler
// Macro REGBANK_SCOREBOARD_EN adds the busy[] scoreboard output.
module regbank_wb_arbiter #(
  parameter int DW           = 32,
  parameter int NREG         = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regbank_wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic            alu_full, ldr_full;
  logic [AW-1:0]   alu_dest_q, ldr_dest_q;
  logic [DW-1:0]   alu_data_q, ldr_data_q;
  logic            age_alu_older;
  logic [SW-1:0]   starve_cnt;
  logic [NREG-1:0] en_q;
  logic [DW-1:0]   wdata_q;

  logic alu_win, alu_grant, ldr_grant;
  logic alu_ready, ldr_ready, alu_load, ldr_load;

  always_comb begin
    alu_win = 1'b0;
    if (alu_full && ldr_full) begin
      if (alu_dest_q == ldr_dest_q)
        alu_win = age_alu_older;
      else if (starve_cnt == SW'(STARVE_LIMIT))
        alu_win = 1'b1;
    end
    alu_grant = alu_full & (~ldr_full | alu_win);
    ldr_grant = ldr_full & ~alu_grant;
  end

  // Ready depends only on slot state and flush so a source never sees a valid->ready loop.
  assign alu_ready = ~bus.flush & (~alu_full | alu_grant);
  assign ldr_ready = ~bus.flush & (~ldr_full | ldr_grant);
  assign alu_load  = bus.alu_valid & alu_ready;
  assign ldr_load  = bus.ldr_valid & ldr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full      <= 1'b0;
      ldr_full      <= 1'b0;
      alu_dest_q    <= '0;
      ldr_dest_q    <= '0;
      alu_data_q    <= '0;
      ldr_data_q    <= '0;
      age_alu_older <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      if (bus.flush)     alu_full <= 1'b0;
      else if (alu_load) alu_full <= 1'b1;
      else if (alu_grant) alu_full <= 1'b0;

      if (bus.flush)     ldr_full <= 1'b0;
      else if (ldr_load) ldr_full <= 1'b1;
      else if (ldr_grant) ldr_full <= 1'b0;

      if (alu_load) begin
        alu_dest_q <= bus.alu_dest;
        alu_data_q <= bus.alu_data;
      end
      if (ldr_load) begin
        ldr_dest_q <= bus.ldr_dest;
        ldr_data_q <= bus.ldr_data;
      end

      // Simultaneous arrivals are ordered load-first.
      if (alu_load && ldr_load)
        age_alu_older <= 1'b0;
      else if (alu_load)
        age_alu_older <= ~ldr_full | ldr_grant;
      else if (ldr_load)
        age_alu_older <= alu_full & ~alu_grant;

      if (bus.flush || alu_grant || !alu_full)
        starve_cnt <= '0;
      else if (ldr_grant && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= '0;
      wdata_q <= '0;
    end else if (alu_grant) begin
      en_q    <= NREG'(1) << alu_dest_q;
      wdata_q <= alu_data_q;
    end else if (ldr_grant) begin
      en_q    <= NREG'(1) << ldr_dest_q;
      wdata_q <= ldr_data_q;
    end else begin
      en_q    <= '0;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.ldr_ready = ldr_ready;
  assign bus.en        = en_q;
  assign bus.wdata     = wdata_q;

`ifdef REGBANK_SCOREBOARD_EN
  logic [NREG-1:0] busy_c;
  always_comb begin
    busy_c = en_q;
    for (int i = 0; i < NREG; i++) begin
      if (alu_full && alu_dest_q == AW'(i)) busy_c[i] = 1'b1;
      if (ldr_full && ldr_dest_q == AW'(i)) busy_c[i] = 1'b1;
    end
  end
  assign bus.busy = busy_c;
`endif
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb/tb_regbank_wb_arbiter.sv - directed self-checking bench for regbank_wb_arbiter
// Busy checks compile in only when REGBANK_SCOREBOARD_EN is defined.
module tb_regbank_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  regbank_wb_arbiter_if bus ();

  regbank_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.alu_valid = 1'b0;
    bus.ldr_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset();
    idle();
    bus.alu_dest = '0; bus.alu_data = '0;
    bus.ldr_dest = '0; bus.ldr_data = '0;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.en !== 16'h0000) begin errors++; $display("FAIL reset_en got=%h exp=0000", bus.en); end
    checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata); end
    checks++; if (bus.alu_ready !== 1'b1 || bus.ldr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", bus.alu_ready, bus.ldr_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd5; bus.alu_data = 32'hDEAD_BEEF;
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.en !== 16'h0000) begin errors++; $display("FAIL single_n1_en got=%h exp=0000", bus.en); end
`ifdef REGBANK_SCOREBOARD_EN
    checks++; if (bus.busy !== 16'h0020) begin errors++; $display("FAIL single_busy got=%h exp=0020", bus.busy); end
`endif
    step();
    checks++; if (bus.en !== 16'h0020 || bus.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write en=%h wdata=%h exp=0020/deadbeef", bus.en, bus.wdata); end
    step();
    checks++; if (bus.en !== 16'h0000 || bus.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold en=%h wdata=%h exp=0000/deadbeef", bus.en, bus.wdata); end
    drain();
  endtask

  task automatic test_collision();
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd7; bus.alu_data = 32'h22;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd3; bus.ldr_data = 32'h11;
    step();
    idle();
    checks++; if (bus.alu_ready !== 1'b0 || bus.ldr_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got=%b%b exp=01", bus.alu_ready, bus.ldr_ready); end
    step();
    checks++; if (bus.en !== 16'h0008 || bus.wdata !== 32'h11) begin errors++; $display("FAIL coll_first en=%h wdata=%h exp=0008/11", bus.en, bus.wdata); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready got=%b exp=1", bus.alu_ready); end
    step();
    checks++; if (bus.en !== 16'h0080 || bus.wdata !== 32'h22) begin errors++; $display("FAIL coll_second en=%h wdata=%h exp=0080/22", bus.en, bus.wdata); end
    drain();
  endtask

  task automatic test_same_dest();
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd9; bus.alu_data = 32'hB;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd9; bus.ldr_data = 32'hA;
    step();
    idle();
    step();
    checks++; if (bus.en !== 16'h0200 || bus.wdata !== 32'hA) begin errors++; $display("FAIL same_first en=%h wdata=%h exp=0200/a", bus.en, bus.wdata); end
    step();
    checks++; if (bus.en !== 16'h0200 || bus.wdata !== 32'hB) begin errors++; $display("FAIL same_second en=%h wdata=%h exp=0200/b", bus.en, bus.wdata); end
    drain();
    // ALU entry held behind a load becomes older than the next same-dest load.
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd9; bus.alu_data = 32'hC;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd4; bus.ldr_data = 32'hE;
    step();
    bus.alu_valid = 1'b0;
    bus.ldr_dest = 4'd9; bus.ldr_data = 32'hD;
    step();
    bus.ldr_valid = 1'b0;
    checks++; if (bus.en !== 16'h0010 || bus.wdata !== 32'hE) begin errors++; $display("FAIL age_first en=%h wdata=%h exp=0010/e", bus.en, bus.wdata); end
    step();
    checks++; if (bus.en !== 16'h0200 || bus.wdata !== 32'hC) begin errors++; $display("FAIL age_alu en=%h wdata=%h exp=0200/c", bus.en, bus.wdata); end
    step();
    checks++; if (bus.en !== 16'h0200 || bus.wdata !== 32'hD) begin errors++; $display("FAIL age_ldr en=%h wdata=%h exp=0200/d", bus.en, bus.wdata); end
    drain();
  endtask

  task automatic test_starvation();
    logic [15:0] exp_en;
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd2; bus.alu_data = 32'h200;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd1; bus.ldr_data = 32'h100;
    step();
    for (int k = 0; k < 12; k++) begin
      step();
      exp_en = (k % 4 == 3) ? 16'h0004 : 16'h0002;
      checks++; if (bus.en !== exp_en) begin errors++; $display("FAIL starve_k%0d en=%h exp=%h", k, bus.en, exp_en); end
      checks++; if (!$onehot0(bus.en)) begin errors++; $display("FAIL starve_onehot_k%0d en=%h exp=onehot", k, bus.en); end
    end
    drain();
  endtask

  task automatic test_flush();
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd7; bus.alu_data = 32'h77;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd3; bus.ldr_data = 32'h33;
    step();
    idle();
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.alu_ready !== 1'b0 || bus.ldr_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b%b exp=00", bus.alu_ready, bus.ldr_ready); end
    step();
    bus.flush = 1'b0;
    checks++; if (bus.en !== 16'h0008 || bus.wdata !== 32'h33) begin errors++; $display("FAIL flush_grant en=%h wdata=%h exp=0008/33", bus.en, bus.wdata); end
    step();
    checks++; if (bus.en !== 16'h0000) begin errors++; $display("FAIL flush_nowrite en=%h exp=0000", bus.en); end
    checks++; if (bus.alu_ready !== 1'b1 || bus.ldr_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got=%b%b exp=11", bus.alu_ready, bus.ldr_ready); end
`ifdef REGBANK_SCOREBOARD_EN
    checks++; if (bus.busy !== 16'h0000) begin errors++; $display("FAIL flush_busy got=%h exp=0000", bus.busy); end
`endif
    step();
    checks++; if (bus.en !== 16'h0000) begin errors++; $display("FAIL flush_nowrite2 en=%h exp=0000", bus.en); end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd6; bus.alu_data = 32'h66;
    bus.ldr_valid = 1'b1; bus.ldr_dest = 4'd2; bus.ldr_data = 32'h55;
    step();
    step();
    idle();
    checks++; if (bus.en !== 16'h0004) begin errors++; $display("FAIL rstmid_pre en=%h exp=0004", bus.en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.en !== 16'h0000 || bus.wdata !== 32'h0) begin errors++; $display("FAIL rstmid_async en=%h wdata=%h exp=0000/0", bus.en, bus.wdata); end
    step();
    rst_n = 1'b1;
    checks++; if (bus.alu_ready !== 1'b1 || bus.ldr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b%b exp=11", bus.alu_ready, bus.ldr_ready); end
    repeat (2) begin
      step();
      checks++; if (bus.en !== 16'h0000) begin errors++; $display("FAIL rstmid_discard en=%h exp=0000", bus.en); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_same_dest();
    test_starvation();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
